wdt_timer_core: RTL and testbench
=================================

// Module: wdt_timer_core
// PURPOSE
//  Watchdog counting engine directly downstream of the AXI write-slave WDT register front-end.
//  Consumes the front-end's one-cycle control strobes (enable, kick, timeout-load) and runs a
//  prescaled up-counter against the loaded timeout value. Raises sticky WTO on expiry for the
//  system reset / interrupt controller. Single clock domain, ACLK.
// PARAMETERS
//  CNT_W       32  width of timeout value and counter (matches AXI data width)
//  PRESCALE    1   ACLK cycles per counter tick; legal range 1..65535
// PORTS
//  ACLK        in   1      clock
//  ARESETn     in   1      reset, asynchronous, active-low
//  wden_i      in   1      enable level; 0 forces IDLE, has top priority
//  wdlive_i    in   1      kick; acts on 0->1 edge only, via internal registered edge detect
//  wtocnt_i    in   CNT_W  timeout value, sampled when wtocnt_ld_i=1
//  wtocnt_ld_i in   1      one-cycle load strobe for wtocnt_i
//  wto_o       out  1      registered timeout flag, sticky
//  cnt_o       out  CNT_W  current counter value, for status readback
//  warn_o      out  1      early-warning pulse; tied 0 unless WDT_WARN_EN is defined
// BEHAVIOUR
//  Reset values: state=IDLE, reload_q=0, cnt_q=0, prescaler=0, live_d=0; wto_o=0, cnt_o=0, warn_o=0.
//  kick = wdlive_i & ~live_d. Level-held wdlive_i counts as one kick only.
//  tick = one-cycle pulse every PRESCALE cycles. Prescaler runs only in RUN and clears on leaving RUN.
//  wtocnt_ld_i=1 sets reload_q<=wtocnt_i in any state. Loads during IDLE and EXPIRED are kept.
//  FSM states and transitions (priority top-down):
//   IDLE:    cnt_q=0, wto_o=0. If wden_i & reload_eff!=0, go to RUN with cnt_q=0.
//            reload_eff = wtocnt_ld_i ? wtocnt_i : reload_q.
//   RUN:     wden_i=0                       -> IDLE, cnt_q<=0.
//            ld with wtocnt_i==0            -> IDLE. A timeout of 0 means disabled.
//            kick or ld                     -> cnt_q<=0, prescaler<=0, stay in RUN.
//            tick & cnt_q==reload_q-1       -> EXPIRED, cnt_q<=reload_q, wto_o<=1 on the same edge.
//            tick                           -> cnt_q<=cnt_q+1.
//   EXPIRED: wto_o held 1 and cnt_q frozen. Kicks and loads do not clear it (loads update reload_q).
//            wden_i=0 is the only exit -> IDLE, and wto_o<=0 on that edge.
//  Simultaneous events:
//   - kick on the expiring tick: kick wins, cnt_q<=0, no WTO.
//   - ld and kick in the same cycle: reload_q updated, cnt cleared once.
//   - wden_i=0 overrides everything.
//  Latency: PRESCALE=1, reload=N, wden_i rising at edge k -> RUN at k+1 -> wto_o=1 after edge k+1+N.
//  Arithmetic: cnt_q never exceeds reload_q, so no wrap. Compare is unsigned, full CNT_W.
//  ARESETn asserted mid-count returns all state to reset values immediately (async).
// CONFIGURATION
//  WDT_WARN_EN defined: warn_o pulses exactly one cycle when a tick moves cnt_q to reload_q>>1 in RUN.
//   No pulse if reload_q<2. Re-armed by kick or ld.
//  WDT_WARN_EN undefined: warn_o constant 0 and no warn logic synthesised. Port list is unchanged.
// STRUCTURE
//  wdt_pkg (shared with the register front-end):
//   - typedef enum logic [1:0] wdt_state_e {WDT_IDLE, WDT_RUN, WDT_EXPIRED}.
//   - address constants WDT_ADDR_WDEN=32'h1001_0100, WDT_ADDR_WDLIVE=32'h1001_0200,
//     WDT_ADDR_WTOCNT=32'h1001_0300.
//   - WDT_CNT_W=32.
//  Sub-module wdt_prescaler (PRESCALE param; inputs en, clr; output tick), instantiated once.
//  FSM, reload/counter registers and edge detect stay in wdt_timer_core.
// TESTING (PRESCALE=1 unless stated)
//  1. ld 5, then wden_i=1 at edge k, no kicks -> cnt_o 0..4, wto_o=1 after edge k+6, stays 1 for 20 cycles.
//  2. ld 8, enable, kick pulse every 6 cycles for 100 cycles -> wto_o stays 0, cnt_o max 6.
//  3. ld 4, kick exactly on the cycle of the expiring tick -> no WTO, cnt_o=0 next cycle.
//  4. In EXPIRED, kick and ld 10 -> wto_o stays 1. Drop wden_i -> wto_o=0 next edge, cnt_o=0.
//  5. PRESCALE=4, ld 3, enable -> wto_o rises 12 cycles after RUN entry. Hold wdlive_i high 10 cycles -> one kick only.
//  6. ld 0 while enabled -> IDLE, no WTO. ARESETn low mid-count -> all outputs 0 asynchronously.
//     With WDT_WARN_EN: ld 10 -> single warn_o pulse at cnt_o=5.

Source files
------------

// File: rtl/wdt_pkg.sv
// Shared watchdog definitions: FSM states, register map, data width.
// Used by both the AXI register front-end and the counting engine.
package wdt_pkg;

  localparam int WDT_CNT_W = 32;

  localparam logic [31:0] WDT_ADDR_WDEN   = 32'h1001_0100;
  localparam logic [31:0] WDT_ADDR_WDLIVE = 32'h1001_0200;
  localparam logic [31:0] WDT_ADDR_WTOCNT = 32'h1001_0300;

  typedef enum logic [1:0] {
    WDT_IDLE,
    WDT_RUN,
    WDT_EXPIRED
  } wdt_state_e;

endpackage

// File: rtl/wdt_timer_core_if.sv
// Control-strobe / status bundle between the WDT register front-end
// (master) and the watchdog counting engine (slave).
interface wdt_timer_core_if
  import wdt_pkg::*;
#(
  parameter int CNT_W = WDT_CNT_W
);

  logic             wden_i;
  logic             wdlive_i;
  logic [CNT_W-1:0] wtocnt_i;
  logic             wtocnt_ld_i;
  logic             wto_o;
  logic [CNT_W-1:0] cnt_o;
  logic             warn_o;

  modport master (
    output wden_i, wdlive_i, wtocnt_i, wtocnt_ld_i,
    input  wto_o, cnt_o, warn_o
  );

  modport slave (
    input  wden_i, wdlive_i, wtocnt_i, wtocnt_ld_i,
    output wto_o, cnt_o, warn_o
  );

endinterface

// File: rtl/wdt_prescaler.sv
// Tick generator: one-cycle pulse every PRESCALE enabled cycles.
// Held at zero while disabled or cleared.
module wdt_prescaler #(
  parameter int PRESCALE = 1
) (
  input  logic ACLK,
  input  logic ARESETn,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);

  logic [PW-1:0] r_div;

  assign tick = en & (r_div == LAST);

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      r_div <= '0;
    end else if (!en || clr || tick) begin
      r_div <= '0;
    end else begin
      r_div <= r_div + 1'b1;
    end
  end

endmodule

// File: rtl/wdt_timer_core.sv
// Watchdog counting engine: prescaled up-counter vs loaded timeout, sticky WTO.
// Define WDT_WARN_EN to build the half-way early-warning pulse on warn_o.
module wdt_timer_core
  import wdt_pkg::*;
#(
  parameter int CNT_W    = WDT_CNT_W,
  parameter int PRESCALE = 1
) (
  input  logic             ACLK,
  input  logic             ARESETn,
  wdt_timer_core_if.slave  bus
);

  wdt_state_e       r_state;
  logic [CNT_W-1:0] r_reload;
  logic [CNT_W-1:0] r_cnt;
  logic             r_live_d;
  logic             r_wto;

  logic             w_kick;
  logic             w_ld;
  logic             w_tick;
  logic             w_expire;
  logic [CNT_W-1:0] w_reload_eff;

  assign w_kick       = bus.wdlive_i & ~r_live_d;
  assign w_ld         = bus.wtocnt_ld_i;
  assign w_reload_eff = w_ld ? bus.wtocnt_i : r_reload;
  assign w_expire     = w_tick & (r_cnt == r_reload - CNT_W'(1));

  wdt_prescaler #(
    .PRESCALE (PRESCALE)
  ) u_presc (
    .ACLK    (ACLK),
    .ARESETn (ARESETn),
    .en      (r_state == WDT_RUN),
    .clr     (w_kick | w_ld),
    .tick    (w_tick)
  );

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      r_live_d <= 1'b0;
      r_reload <= '0;
    end else begin
      r_live_d <= bus.wdlive_i;
      if (w_ld) r_reload <= bus.wtocnt_i;
    end
  end

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      r_state <= WDT_IDLE;
      r_cnt   <= '0;
      r_wto   <= 1'b0;
    end else begin
      unique case (r_state)
        WDT_IDLE: begin
          r_cnt <= '0;
          r_wto <= 1'b0;
          if (bus.wden_i && w_reload_eff != '0)
            r_state <= WDT_RUN;
        end
        WDT_RUN: begin
          if (!bus.wden_i) begin
            r_state <= WDT_IDLE;
            r_cnt   <= '0;
          end else if (w_ld && bus.wtocnt_i == '0) begin
            // zero timeout means watchdog disabled
            r_state <= WDT_IDLE;
            r_cnt   <= '0;
          end else if (w_kick || w_ld) begin
            r_cnt <= '0;
          end else if (w_expire) begin
            r_state <= WDT_EXPIRED;
            r_cnt   <= r_reload;
            r_wto   <= 1'b1;
          end else if (w_tick) begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        WDT_EXPIRED: begin
          if (!bus.wden_i) begin
            r_state <= WDT_IDLE;
            r_cnt   <= '0;
            r_wto   <= 1'b0;
          end
        end
        default: begin
          r_state <= WDT_IDLE;
          r_cnt   <= '0;
          r_wto   <= 1'b0;
        end
      endcase
    end
  end

  assign bus.wto_o = r_wto;
  assign bus.cnt_o = r_cnt;

`ifdef WDT_WARN_EN
  logic r_warn;
  logic w_warn_hit;

  // plain tick landing exactly on the half-way count
  assign w_warn_hit = (r_state == WDT_RUN) & bus.wden_i
                    & ~w_ld & ~w_kick & w_tick & ~w_expire
                    & (r_reload >= CNT_W'(2))
                    & ((r_cnt + 1'b1) == (r_reload >> 1));

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) r_warn <= 1'b0;
    else          r_warn <= w_warn_hit;
  end

  assign bus.warn_o = r_warn;
`else
  assign bus.warn_o = 1'b0;
`endif

endmodule

// File: tb/tb_wdt_timer_core.sv
// Scoreboard bench for wdt_timer_core: PRESCALE=1 and PRESCALE=4 instances.
// Expected post-edge outputs are queued with the stimulus, checked #1 after the edge.
module tb_wdt_timer_core;

`ifdef WDT_WARN_EN
  localparam bit WARN_EN = 1'b1;
`else
  localparam bit WARN_EN = 1'b0;
`endif

  typedef struct {
    string       tag;
    int          which;
    logic [31:0] cnt;
    logic        wto;
    bit          cw;
    logic        warn;
  } exp_t;

  logic ACLK = 1'b0;
  logic ARESETn;

  int n_chk = 0;
  int n_err = 0;
  int maxc;
  int ecnt;
  bit kick;
  exp_t sb[$];

  always #5 ACLK = ~ACLK;

  wdt_timer_core_if #(.CNT_W(32)) bus ();
  wdt_timer_core_if #(.CNT_W(32)) bus4 ();

  wdt_timer_core #(
    .CNT_W    (32),
    .PRESCALE (1)
  ) u_dut (
    .ACLK    (ACLK),
    .ARESETn (ARESETn),
    .bus     (bus)
  );

  wdt_timer_core #(
    .CNT_W    (32),
    .PRESCALE (4)
  ) u_dut4 (
    .ACLK    (ACLK),
    .ARESETn (ARESETn),
    .bus     (bus4)
  );

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push(string tag, int which, logic [31:0] cnt,
                      logic wto, bit cw = 1'b0, logic warn = 1'b0);
    exp_t e;
    e.tag   = tag;
    e.which = which;
    e.cnt   = cnt;
    e.wto   = wto;
    e.cw    = cw;
    e.warn  = warn;
    sb.push_back(e);
  endtask

  task automatic cyc(int n = 1);
    exp_t e;
    repeat (n) begin
      @(posedge ACLK);
      #1;
      while (sb.size() > 0) begin
        e = sb.pop_front();
        if (e.which == 0) begin
          chk({e.tag, "_cnt"}, bus.cnt_o, e.cnt);
          chk({e.tag, "_wto"}, 32'(bus.wto_o), 32'(e.wto));
          if (e.cw) chk({e.tag, "_warn"}, 32'(bus.warn_o), 32'(e.warn));
        end else begin
          chk({e.tag, "_cnt4"}, bus4.cnt_o, e.cnt);
          chk({e.tag, "_wto4"}, 32'(bus4.wto_o), 32'(e.wto));
        end
      end
    end
  endtask

  task automatic idle_inputs();
    bus.wden_i       = 1'b0;
    bus.wdlive_i     = 1'b0;
    bus.wtocnt_i     = '0;
    bus.wtocnt_ld_i  = 1'b0;
    bus4.wden_i      = 1'b0;
    bus4.wdlive_i    = 1'b0;
    bus4.wtocnt_i    = '0;
    bus4.wtocnt_ld_i = 1'b0;
  endtask

  initial begin
    ARESETn = 1'b0;
    idle_inputs();
    #12;
    chk("rst_cnt", bus.cnt_o, 32'd0);
    chk("rst_wto", 32'(bus.wto_o), 32'd0);
    chk("rst_warn", 32'(bus.warn_o), 32'd0);
    chk("rst_cnt4", bus4.cnt_o, 32'd0);
    chk("rst_wto4", 32'(bus4.wto_o), 32'd0);
    @(negedge ACLK);
    ARESETn = 1'b1;
    cyc();

    // basic expiry, reload 5
    bus.wtocnt_ld_i = 1'b1;
    bus.wtocnt_i    = 32'd5;
    push("t1_ld", 0, 0, 0);
    cyc();
    bus.wtocnt_ld_i = 1'b0;
    bus.wden_i      = 1'b1;
    push("t1_run", 0, 0, 0);
    cyc();
    for (int j = 1; j <= 4; j++) begin
      push("t1_cnt", 0, 32'(j), 0);
      cyc();
    end
    push("t1_exp", 0, 5, 1);
    cyc();
    repeat (20) begin
      push("t1_hold", 0, 5, 1);
      cyc();
    end

    // kick and load are ignored while expired
    bus.wdlive_i    = 1'b1;
    bus.wtocnt_ld_i = 1'b1;
    bus.wtocnt_i    = 32'd10;
    push("t4_kick", 0, 5, 1);
    cyc();
    bus.wdlive_i    = 1'b0;
    bus.wtocnt_ld_i = 1'b0;
    push("t4_hold", 0, 5, 1);
    cyc();
    bus.wden_i = 1'b0;
    push("t4_exit", 0, 0, 0);
    cyc();
    push("t4_idle", 0, 0, 0);
    cyc();

    // periodic kicks keep it alive
    bus.wtocnt_ld_i = 1'b1;
    bus.wtocnt_i    = 32'd8;
    bus.wden_i      = 1'b1;
    push("t2_run", 0, 0, 0);
    cyc();
    bus.wtocnt_ld_i = 1'b0;
    ecnt = 0;
    maxc = 0;
    for (int i = 0; i < 100; i++) begin
      kick = (i % 6 == 5);
      bus.wdlive_i = kick;
      ecnt = kick ? 0 : ecnt + 1;
      push("t2_cnt", 0, 32'(ecnt), 0);
      cyc();
      if (int'(bus.cnt_o) > maxc) maxc = int'(bus.cnt_o);
    end
    chk("t2_max_le6", 32'(maxc <= 6), 32'd1);
    bus.wdlive_i = 1'b0;
    bus.wden_i   = 1'b0;
    push("t2_off", 0, 0, 0);
    cyc();

    // kick on the expiring tick wins
    bus.wtocnt_ld_i = 1'b1;
    bus.wtocnt_i    = 32'd4;
    bus.wden_i      = 1'b1;
    push("t3_run", 0, 0, 0);
    cyc();
    bus.wtocnt_ld_i = 1'b0;
    for (int j = 1; j <= 3; j++) begin
      push("t3_cnt", 0, 32'(j), 0);
      cyc();
    end
    bus.wdlive_i = 1'b1;
    push("t3_kick", 0, 0, 0);
    cyc();
    bus.wdlive_i = 1'b0;
    push("t3_after", 0, 1, 0);
    cyc();
    bus.wden_i = 1'b0;
    push("t3_off", 0, 0, 0);
    cyc();

    // PRESCALE=4: 3 ticks of 4 cycles
    bus4.wtocnt_ld_i = 1'b1;
    bus4.wtocnt_i    = 32'd3;
    bus4.wden_i      = 1'b1;
    push("t5_run", 1, 0, 0);
    cyc();
    bus4.wtocnt_ld_i = 1'b0;
    for (int j = 1; j <= 11; j++) begin
      push("t5_cnt", 1, 32'(j / 4), 0);
      cyc();
    end
    push("t5_exp", 1, 3, 1);
    cyc();
    bus4.wden_i = 1'b0;
    push("t5_off", 1, 0, 0);
    cyc();
    bus4.wden_i = 1'b1;
    push("t5_run2", 1, 0, 0);
    cyc();
    // level-held wdlive_i: only the first edge kicks
    bus4.wdlive_i = 1'b1;
    for (int j = 0; j <= 9; j++) begin
      push("t5_hold", 1, 32'(j / 4), 0);
      cyc();
    end
    bus4.wdlive_i = 1'b0;
    for (int j = 10; j <= 11; j++) begin
      push("t5_rel", 1, 32'(j / 4), 0);
      cyc();
    end
    push("t5_exp2", 1, 3, 1);
    cyc();

    // zero timeout disables, then async reset mid-count
    bus.wden_i = 1'b1;
    push("t6_run", 0, 0, 0);
    cyc();
    push("t6_cnt", 0, 1, 0);
    cyc();
    bus.wtocnt_ld_i = 1'b1;
    bus.wtocnt_i    = 32'd0;
    push("t6_ld0", 0, 0, 0);
    cyc();
    bus.wtocnt_ld_i = 1'b0;
    repeat (3) begin
      push("t6_idle", 0, 0, 0);
      cyc();
    end
    bus.wtocnt_ld_i = 1'b1;
    bus.wtocnt_i    = 32'd6;
    push("t6_run2", 0, 0, 0);
    cyc();
    bus.wtocnt_ld_i = 1'b0;
    push("t6_c1", 0, 1, 0);
    cyc();
    push("t6_c2", 0, 2, 0);
    cyc();
    #2;
    ARESETn = 1'b0;
    #1;
    chk("t6_arst_cnt", bus.cnt_o, 32'd0);
    chk("t6_arst_wto", 32'(bus.wto_o), 32'd0);
    chk("t6_arst_warn", 32'(bus.warn_o), 32'd0);
    chk("t6_arst_cnt4", bus4.cnt_o, 32'd0);
    chk("t6_arst_wto4", 32'(bus4.wto_o), 32'd0);
    idle_inputs();
    @(negedge ACLK);
    ARESETn = 1'b1;
    cyc();

    // half-way warning, reload 10
    bus.wtocnt_ld_i = 1'b1;
    bus.wtocnt_i    = 32'd10;
    bus.wden_i      = 1'b1;
    push("t7_run", 0, 0, 0, 1'b1, 1'b0);
    cyc();
    bus.wtocnt_ld_i = 1'b0;
    for (int j = 1; j <= 9; j++) begin
      push("t7_cnt", 0, 32'(j), 0, 1'b1, WARN_EN && (j == 5));
      cyc();
    end
    push("t7_exp", 0, 10, 1, 1'b1, 1'b0);
    cyc();
    push("t7_hold", 0, 10, 1, 1'b1, 1'b0);
    cyc();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
